// File: rtl/muldiv_unit_if.sv
// SFR-side bus of the multiply/divide engine: operand/start handshake in,
// SFR write port and PSW flags out.
interface muldiv_unit_if;
  logic       start;
  logic       op;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       busy;
  logic       wr_en;
  logic       wr_bit_en;
  logic [7:0] addr;
  logic [7:0] data_out;
  logic       done;
  logic       ov;
  logic       cy;

  modport master (
    output start, op, a_in, b_in,
    input  busy, wr_en, wr_bit_en, addr, data_out, done, ov, cy
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, wr_en, wr_bit_en, addr, data_out, done, ov, cy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Bit-serial 8051 MUL AB / DIV AB engine. Eight compute cycles, then ACC and
// B are written back on consecutive cycles, then a one-cycle done with OV/CY.
module muldiv_unit #(
  parameter logic [7:0] SFR_ACC_ADDR = 8'hE0,
  parameter logic [7:0] SFR_B_ADDR   = 8'hF0
) (
  input  logic         clock,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CALC, WB_ACC, WB_B, FIN} state_t;

  typedef struct packed {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  state_t      state;
  req_t        req;
  logic [2:0]  cnt;
  logic [15:0] prod;
  logic [7:0]  rem;
  logic [7:0]  quot;
  logic        ov_q;

  // One restoring-division step and one shift-add step, from latched operands.
  logic [8:0]  shifted;
  logic [8:0]  diff;
  logic        ge;
  logic [15:0] addend;

  assign shifted = {rem, req.a[3'd7 - cnt]};
  assign ge      = shifted >= {1'b0, req.b};
  assign diff    = shifted - {1'b0, req.b};
  assign addend  = req.b[cnt] ? ({8'h00, req.a} << cnt) : 16'h0000;

  // Sequencer and datapath; async reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      req   <= '0;
      cnt   <= '0;
      prod  <= '0;
      rem   <= '0;
      quot  <= '0;
      ov_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          req   <= '{op: bus.op, a: bus.a_in, b: bus.b_in};
          cnt   <= '0;
          prod  <= '0;
          rem   <= '0;
          quot  <= '0;
          // Divide by zero goes straight to FIN, so OV must already be set.
          ov_q  <= bus.op && (bus.b_in == 8'h00);
          state <= (bus.op && (bus.b_in == 8'h00)) ? FIN : CALC;
        end
        CALC: begin
          cnt <= cnt + 3'd1;
          if (req.op) begin
            // Remainder stays below the divisor, so 8 bits always suffice.
            rem  <= ge ? diff[7:0] : shifted[7:0];
            quot <= {quot[6:0], ge};
          end else begin
            prod <= prod + addend;
          end
          if (cnt == 3'd7) state <= WB_ACC;
        end
        WB_ACC: state <= WB_B;
        WB_B: begin
          ov_q  <= !req.op && (prod[15:8] != 8'h00);
          state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only.
  assign bus.busy      = (state != IDLE);
  assign bus.wr_en     = (state == WB_ACC) || (state == WB_B);
  assign bus.wr_bit_en = 1'b0;
  assign bus.addr      = (state == WB_ACC) ? SFR_ACC_ADDR :
                         (state == WB_B)   ? SFR_B_ADDR   : 8'h00;
  assign bus.data_out  = (state == WB_ACC) ? (req.op ? quot : prod[7:0]) :
                         (state == WB_B)   ? (req.op ? rem  : prod[15:8]) : 8'h00;
  assign bus.done      = (state == FIN);
  assign bus.ov        = ov_q;
  assign bus.cy        = 1'b0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed test-plan cases plus random MUL/DIV ops,
// checked against plain a*b, a/b, a%b arithmetic.
module tb_muldiv_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  muldiv_unit_if bus ();

  muldiv_unit #(.SFR_ACC_ADDR(8'hE0), .SFR_B_ADDR(8'hF0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Run one operation; start is re-pulsed in cycles ign1/ign2 (0 = none).
  // a_in/b_in are scrambled after acceptance and overwritten by the unit's
  // own writes to mimic the ACC/B registers feeding back.
  task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                        input int ign1, input int ign2);
    logic [15:0] p;
    logic        dz;
    logic [7:0]  e_acc, e_b;
    int wcnt, acc_cyc, b_cyc, done_cyc, done_cnt, busy_cnt;
    logic [7:0] acc_dat, b_dat;
    logic ov_done, cy_done, ov_c1;
    dz    = o && (b == 8'h00);
    p     = 16'(a) * 16'(b);
    e_acc = o ? (dz ? 8'h00 : a / b) : p[7:0];
    e_b   = o ? (dz ? 8'h00 : a % b) : p[15:8];
    wcnt = 0; acc_cyc = 0; b_cyc = 0; done_cyc = 0; done_cnt = 0; busy_cnt = 0;
    acc_dat = 8'h00; b_dat = 8'h00; ov_done = 1'b0; cy_done = 1'b1; ov_c1 = 1'b1;
    @(negedge clock);
    bus.start = 1'b1; bus.op = o; bus.a_in = a; bus.b_in = b;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      bus.start = (k == ign1 || k == ign2);
      bus.op    = 1'($urandom);
      if (k == 1) ov_c1 = bus.ov;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = k; ov_done = bus.ov; cy_done = bus.cy;
        end
      end
      if (bus.wr_en) begin
        wcnt++;
        if (bus.addr == 8'hE0) begin acc_cyc = k; acc_dat = bus.data_out; bus.a_in = bus.data_out; end
        else if (bus.addr == 8'hF0) begin b_cyc = k; b_dat = bus.data_out; bus.b_in = bus.data_out; end
      end else begin
        bus.a_in = 8'($urandom);
        bus.b_in = 8'($urandom);
      end
    end
    check("wr_count", 16'(wcnt), dz ? 16'd0 : 16'd2);
    if (!dz) begin
      check("acc_data", {8'h00, acc_dat}, {8'h00, e_acc});
      check("acc_cycle", 16'(acc_cyc), 16'd9);
      check("b_data", {8'h00, b_dat}, {8'h00, e_b});
      check("b_cycle", 16'(b_cyc), 16'd10);
      check("ov_cleared_c1", {15'h0, ov_c1}, 16'h0);
    end
    check("done_cycle", 16'(done_cyc), dz ? 16'd1 : 16'd11);
    check("done_count", 16'(done_cnt), 16'd1);
    check("busy_cycles", 16'(busy_cnt), dz ? 16'd1 : 16'd11);
    check("ov_at_done", {15'h0, ov_done}, {15'h0, (dz || (!o && p[15:8] != 8'h00))});
    check("cy_at_done", {15'h0, cy_done}, 16'h0);
    check("ov_held", {15'h0, bus.ov}, {15'h0, (dz || (!o && p[15:8] != 8'h00))});
    check("idle_outputs", {bus.addr, bus.data_out}, 16'h0000);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       ro;
    int         wr_seen;
    bus.start = 1'b0; bus.op = 1'b0; bus.a_in = 8'h00; bus.b_in = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy_wr_done", {13'h0, bus.busy, bus.wr_en, bus.done}, 16'h0);
    check("rst_flags", {13'h0, bus.wr_bit_en, bus.ov, bus.cy}, 16'h0);
    check("rst_addr_data", {bus.addr, bus.data_out}, 16'h0000);
    reset = 1'b0;

    // Directed test-plan operations.
    run_op(1'b0, 8'h12, 8'h05, 0, 0);
    run_op(1'b0, 8'h50, 8'hA0, 0, 0);
    run_op(1'b0, 8'hFF, 8'hFF, 0, 0);
    run_op(1'b1, 8'hFB, 8'h12, 0, 0);
    run_op(1'b1, 8'h07, 8'h09, 0, 0);
    run_op(1'b1, 8'h40, 8'h00, 0, 0);
    run_op(1'b0, 8'h02, 8'h03, 0, 0);
    run_op(1'b1, 8'hC8, 8'h0F, 3, 10);

    // Reset in cycle 5 of CALC aborts at once with no writes.
    wr_seen = 0;
    @(negedge clock);
    bus.start = 1'b1; bus.op = 1'b0; bus.a_in = 8'h77; bus.b_in = 8'h66;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (bus.wr_en) wr_seen++;
    end
    check("pre_reset_busy", {15'h0, bus.busy}, 16'h1);
    reset = 1'b1;
    #1;
    check("abort_busy_wr_done", {13'h0, bus.busy, bus.wr_en, bus.done}, 16'h0);
    check("abort_addr_data", {bus.addr, bus.data_out}, 16'h0000);
    check("abort_ov_cy", {14'h0, bus.ov, bus.cy}, 16'h0);
    repeat (3) begin
      @(negedge clock);
      if (bus.wr_en) wr_seen++;
    end
    reset = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (bus.wr_en || bus.busy) wr_seen++;
    end
    check("abort_no_writes", 16'(wr_seen), 16'd0);
    run_op(1'b0, 8'h03, 8'h04, 0, 0);

    // Random operations, with divisor zero now and then.
    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom);
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_op(ro, ra, rb, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 8-bit multiply/divide engine that executes the 8051 MUL AB and DIV AB instructions. It sits directly upstream of the accumulator and B special-function registers. It computes bit-serially over 8 cycles, then drives the SFR write bus in two consecutive cycles: ACC first, then B. Finally it presents OV/CY to the PSW logic with a one-cycle done strobe.

## Interface
Parameters:
- SFR_ACC_ADDR, 8'hE0, direct address driven when writing the ACC result
- SFR_B_ADDR, 8'hF0, direct address driven when writing the B result

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high
- start  input  1  begin operation; sampled only in IDLE
- op  input  1  0 = MUL AB, 1 = DIV AB
- a_in  input  8  current ACC value (multiplicand / dividend)
- b_in  input  8  current B value (multiplier / divisor)
- busy  output  1  high from the cycle after start is accepted until the FIN cycle inclusive
- wr_en  output  1  SFR write strobe
- wr_bit_en  output  1  constant 0 (byte writes only)
- addr  output  8  SFR address during writes; 8'h00 otherwise
- data_out  output  8  SFR write data; 8'h00 when wr_en = 0
- done  output  1  one-cycle pulse in FIN
- ov  output  1  overflow flag, held until the next accepted start
- cy  output  1  carry flag; always 0 after any operation

## Operation
- States: IDLE, CALC, WB_ACC, WB_B, FIN.
- IDLE: if start = 1, latch a_in, b_in and op, clear ov, and clear the counter.
  - If op = 1 and b_in = 0 (divide by zero), go to FIN.
  - Otherwise go to CALC.
- CALC, MUL: shift-add, LSB of the multiplier first. A 16-bit product accumulates and the counter increments once per cycle. Leave CALC when the counter reaches 7, i.e. after 8 cycles.
- CALC, DIV: restoring division, MSB of the dividend first. Each cycle:
  - Shift a 9-bit partial remainder left and bring in the next dividend bit.
  - Trial-subtract the divisor.
  - Set the quotient bit to 1 if the result is non-negative, and keep the difference.
  - Otherwise set the quotient bit to 0 and restore.
  - Leave CALC after 8 cycles.
- WB_ACC: wr_en = 1, addr = SFR_ACC_ADDR, data_out = product[7:0] for MUL or the quotient for DIV.
- WB_B: wr_en = 1, addr = SFR_B_ADDR, data_out = product[15:8] for MUL or the remainder for DIV.
- FIN: done = 1 and cy = 0.
  - MUL: ov = 1 if product[15:8] != 0.
  - DIV: ov = 1 only for divide by zero.
  - Next state is IDLE.
- Divide by zero: no SFR write occurs; ACC and B keep their prior values; ov = 1.
- start is ignored in every state except IDLE. A start level still high in the cycle after FIN begins a new operation.
- Operands are latched. Changes on a_in/b_in after acceptance have no effect, including changes caused by the unit's own writes.

## Timing
- Reset: state = IDLE; busy, wr_en, wr_bit_en, done, ov and cy are all 0; addr = 8'h00 and data_out = 8'h00; internal registers are cleared.
- Reset mid-operation aborts immediately. No further writes occur, and any write strobe present is removed asynchronously.
- All outputs are registered or decoded from registered state only. There is no combinational path from the inputs.
- Normal operation, with start accepted at edge 0:
  - CALC occupies cycles 1–8.
  - WB_ACC is cycle 9 and WB_B is cycle 10.
  - FIN is cycle 11, with done = 1.
  - busy = 1 in cycles 1–11.
  - Total latency is 11 cycles.
- Divide by zero: FIN is cycle 1 (done and busy = 1, ov = 1), then IDLE in cycle 2.
- Downstream SFRs capture the write at the rising edge ending WB_ACC or WB_B. The ACC value therefore changes at the start of cycle 10 and B at the start of cycle 11.
- ov and cy update in FIN and are held through subsequent IDLE cycles until the next accepted start clears ov.

## Test plan
- MUL 8'h12 × 8'h05: writes ACC = 8'h5A in cycle 9 and B = 8'h00 in cycle 10; done in cycle 11; ov = 0, cy = 0.
- MUL 8'h50 × 8'hA0 (= 16'h3200): ACC = 8'h00, B = 8'h32, ov = 1. MUL 8'hFF × 8'hFF: ACC = 8'h01, B = 8'hFE, ov = 1.
- DIV 8'hFB ÷ 8'h12: ACC = 8'h0D, B = 8'h11, ov = 0. DIV 8'h07 ÷ 8'h09: ACC = 8'h00, B = 8'h07.
- DIV 8'h40 ÷ 8'h00: done in cycle 1, wr_en never asserts, ov = 1, cy = 0. The following MUL 8'h02 × 8'h03 clears ov and writes ACC = 8'h06.
- Start pulses in cycles 3 and 10 of an active operation are ignored. Only the writes of the first operation appear, and exactly 2 wr_en cycles occur.
- Reset asserted in cycle 5 of CALC: all outputs go to 0 immediately and no write occurs. After release, MUL 8'h03 × 8'h04 completes normally with ACC = 8'h0C.
